pc_gen: RTL and testbench

//   Fetch-stage program counter generator: holds the PC register and selects the next PC.

---
 rtl/pc_gen_pkg.sv | 30 +++
 rtl/pc_gen_btb_table.sv | 72 +++++++
 rtl/pc_gen.sv | 68 ++++++
 tb/tb_pc_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage PC generator and its BTB.
package pc_gen_pkg;

    localparam int          PC_W_MAX     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Tag is stored zero-extended; only the low TAG_W bits are ever non-zero.
    typedef struct packed {
        logic                valid;
        logic [PC_W_MAX-1:0] tag;
        logic [PC_W_MAX-1:0] target;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        case (c)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            default: return taken ? ST  : WT;
        endcase
    endfunction

endpackage

// File: rtl/pc_gen_btb_table.sv
// Direct-mapped BTB: async lookup on the fetch PC, sync training from execute.
module btb_table
    import pc_gen_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                taken,
    output logic [PC_WIDTH-1:0] target,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                upd_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    btb_entry_t entries [BTB_ENTRIES];
    ctr_t       ctrs    [BTB_ENTRIES];

    logic [IDX_W-1:0]    lk_idx;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [TAG_W-1:0]    up_tag;
    logic [PC_WIDTH-1:0] up_tgt;
    logic                lk_hit;
    logic                up_hit;
    logic                unused_bits;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[PC_WIDTH-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[PC_WIDTH-1:IDX_W+2];
    assign up_tgt = {upd_target[PC_WIDTH-1:2], 2'b00};

    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign lk_hit = entries[lk_idx].valid
                  && (entries[lk_idx].tag == PC_W_MAX'(lk_tag));
    assign up_hit = entries[up_idx].valid
                  && (entries[up_idx].tag == PC_W_MAX'(up_tag));

    assign taken  = lk_hit && ctrs[lk_idx][1];
    assign target = lk_hit ? entries[lk_idx].target[PC_WIDTH-1:0]
                           : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries[i] <= '0;
                ctrs[i]    <= WNT;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctrs[up_idx] <= ctr_next(ctrs[up_idx], upd_taken);
                if (upd_taken)
                    entries[up_idx].target <= PC_W_MAX'(up_tgt);
            end else if (upd_taken) begin
                // Miss on a taken branch claims the slot, evicting any alias.
                entries[up_idx].valid  <= 1'b1;
                entries[up_idx].tag    <= PC_W_MAX'(up_tag);
                entries[up_idx].target <= PC_W_MAX'(up_tgt);
                ctrs[up_idx]           <= WT;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with redirect / stall / BTB-predicted next-PC selection.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  BTB_ENTRIES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                update_valid_i,
    input  logic [PC_WIDTH-1:0] update_pc_i,
    input  logic [PC_WIDTH-1:0] update_target_i,
    input  logic                update_taken_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_plus4_o,
    output logic                pred_taken_o,
    output logic [PC_WIDTH-1:0] pred_target_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] redir_pc;
    logic                unused_bits;

    assign redir_pc    = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign unused_bits = ^redirect_pc_i[1:0];

    btb_table #(
        .PC_WIDTH    (PC_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk_i),
        .rst        (rst_i),
        .lookup_pc  (pc_q),
        .taken      (pred_taken_o),
        .target     (pred_target_o),
        .upd_valid  (update_valid_i),
        .upd_pc     (update_pc_i),
        .upd_target (update_target_i),
        .upd_taken  (update_taken_i)
    );

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + PC_WIDTH'(4);

    // Flush beats stall; stall beats prediction.
    always_comb begin
        pc_next = pc_plus4_o;
        if (redirect_i)
            pc_next = redir_pc;
        else if (stall_i)
            pc_next = pc_q;
        else if (pred_taken_o)
            pc_next = pred_target_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_next;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequencing, priority, BTB training, aliasing, wrap.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_target;

    int total = 0;
    int bad   = 0;

    pc_gen dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .update_valid_i  (update_valid),
        .update_pc_i     (update_pc),
        .update_target_i (update_target),
        .update_taken_i  (update_taken),
        .pc_o            (pc),
        .pc_plus4_o      (pc_plus4),
        .pred_taken_o    (pred_taken),
        .pred_target_o   (pred_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t,
                       input logic tk);
        update_valid  = 1'b1;
        update_pc     = p;
        update_target = t;
        update_taken  = tk;
        tick();
        update_valid  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        update_valid  = 1'b0;
        update_pc     = '0;
        update_target = '0;
        update_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_p4", pc_plus4, 32'hBFC0_0004);
        chk("rst_pt", {31'd0, pred_taken}, 32'd0);
        chk("rst_tg", pred_target, 32'd0);

        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq", pc, 32'hBFC0_0000 + 32'(4 * i));
        end
        chk("seq_p4", pc_plus4, 32'hBFC0_0014);

        stall = 1'b1;
        redir(32'hBFC0_0103);
        chk("flush_wins", pc, 32'hBFC0_0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall", pc, 32'hBFC0_0100);
        end
        stall = 1'b0;

        upd(32'hBFC0_0020, 32'hBFC0_0200, 1'b1);
        redir(32'hBFC0_0020);
        chk("trn_pt", {31'd0, pred_taken}, 32'd1);
        chk("trn_tg", pred_target, 32'hBFC0_0200);
        tick();
        chk("trn_jmp", pc, 32'hBFC0_0200);

        // WT -> WNT -> SNT -> SNT, then one taken -> WNT
        upd(32'hBFC0_0020, 32'hBFC0_0200, 1'b0);
        upd(32'hBFC0_0020, 32'hBFC0_0200, 1'b0);
        upd(32'hBFC0_0020, 32'hBFC0_0200, 1'b0);
        upd(32'hBFC0_0020, 32'hBFC0_0300, 1'b1);
        redir(32'hBFC0_0020);
        chk("snt_pt", {31'd0, pred_taken}, 32'd0);
        chk("snt_tg", pred_target, 32'hBFC0_0300);
        tick();
        chk("snt_ft", pc, 32'hBFC0_0024);

        // WNT -> WT -> ST -> ST, then one not-taken -> WT
        upd(32'hBFC0_0020, 32'hBFC0_0300, 1'b1);
        upd(32'hBFC0_0020, 32'hBFC0_0300, 1'b1);
        upd(32'hBFC0_0020, 32'hBFC0_0300, 1'b1);
        upd(32'hBFC0_0020, 32'hBFC0_0300, 1'b0);
        redir(32'hBFC0_0020);
        chk("st_pt", {31'd0, pred_taken}, 32'd1);
        tick();
        chk("st_jmp", pc, 32'hBFC0_0300);

        upd(32'hBFC0_0060, 32'hBFC0_0401, 1'b1);
        redir(32'hBFC0_0020);
        chk("evict_pt", {31'd0, pred_taken}, 32'd0);
        chk("evict_tg", pred_target, 32'd0);
        redir(32'hBFC0_0060);
        chk("alias_pt", {31'd0, pred_taken}, 32'd1);
        chk("alias_tg", pred_target, 32'hBFC0_0400);

        update_valid  = 1'b1;
        update_pc     = 32'hBFC0_0060;
        update_target = 32'hBFC0_0400;
        update_taken  = 1'b0;
        #1;
        chk("same_pt", {31'd0, pred_taken}, 32'd1);
        tick();
        update_valid = 1'b0;
        chk("same_jmp", pc, 32'hBFC0_0400);
        redir(32'hBFC0_0060);
        chk("after_pt", {31'd0, pred_taken}, 32'd0);

        redir(32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'd0);
        tick();
        chk("wrap_nx", pc, 32'd0);

        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'hBFC0_0000);
        chk("arst_pt", {31'd0, pred_taken}, 32'd0);
        tick();
        rst = 1'b0;
        redir(32'hBFC0_0020);
        chk("clr_a_pt", {31'd0, pred_taken}, 32'd0);
        chk("clr_a_tg", pred_target, 32'd0);
        redir(32'hBFC0_0060);
        chk("clr_b_pt", {31'd0, pred_taken}, 32'd0);
        chk("clr_b_tg", pred_target, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
